dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-port data memory, which has a synchronous write, a combinational read and funct3-encoded byte/half/word access.
- Port 0 is the core load/store unit. Port 1 is the DMA/program-loader port.
- Grants at most one access per cycle using round-robin, with an optional bounded lock for port-1 bursts.
- Rejects misaligned accesses and returns registered read data with a one-cycle response.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Port 1 can hold a bounded burst lock; responses are registered one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [2:0]            p0_funct3,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,

  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_funct3,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  input  logic                  p1_lock,

  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // Size field is funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'b01:        bad = a[0];
      2'b10, 2'b11: bad = (a != 2'b00);
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

  logic                  prio_q, prio_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

  logic                  p0_rvalid_q, p0_rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic                  p0_err_q, p0_err_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  p1_err_q, p1_err_d;

  logic gnt0, gnt1;
  logic mis0, mis1;

  assign mis0 = misaligned(p0_funct3[1:0], p0_addr[1:0]);
  assign mis1 = misaligned(p1_funct3[1:0], p1_addr[1:0]);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        if (p1_lock && (burst_cnt_q < MAX_CNT)) begin
          gnt1 = 1'b1;
        end else if (prio_q) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  // Port 0 drives the memory bus whenever port 1 is not granted.
  assign mem_addr   = gnt1 ? p1_addr   : p0_addr;
  assign mem_funct3 = gnt1 ? p1_funct3 : p0_funct3;
  assign mem_wdata  = gnt1 ? p1_wdata  : p0_wdata;
  assign mem_wr_en  = (gnt0 & p0_we & ~mis0) | (gnt1 & p1_we & ~mis1);

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end

    burst_cnt_d = burst_cnt_q;
    if (!p1_lock || gnt0) begin
      burst_cnt_d = '0;
    end else if (gnt1 && p0_req && (burst_cnt_q < MAX_CNT)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // Stores and misaligned accesses return zero data.
  always_comb begin
    p0_rvalid_d = gnt0;
    p0_err_d    = gnt0 & mis0;
    p0_rdata_d  = (gnt0 && !p0_we && !mis0) ? mem_rd_data : '0;
    p1_rvalid_d = gnt1;
    p1_err_d    = gnt1 & mis1;
    p1_rdata_d  = (gnt1 && !p1_we && !mis1) ? mem_rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      burst_cnt_q <= '0;
      p0_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p0_err_q    <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p1_rdata_q  <= '0;
      p1_err_q    <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      burst_cnt_q <= burst_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p1_rdata  = p1_rdata_q;
  assign p1_err    = p1_err_q;

endmodule
